dmem_access_ctrl: RTL and testbench
===================================

# dmem_access_ctrl

Sequencer and arbiter in front of the byte-wide data memory. It accepts load/store requests from two requesters: the core load/store unit (port C) and the program loader/debug port (port L). It grants one request at a time round-robin and performs the transfer as one byte per cycle, little-endian, on a single byte port. Loads return sign- or zero-extended XLEN data.

## Interface
- XLEN, 32, data/address width of requester ports
- ADDR_W, 16, byte address width of memory (depth 2^ADDR_W bytes)
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- c_req_valid / l_req_valid  in  1  request valid (C / L)
- c_req_ready / l_req_ready  out  1  request accepted this cycle when valid&&ready
- c_we / l_we  in  1  1 = store, 0 = load
- c_size / l_size  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- c_addr / l_addr  in  XLEN  byte address
- c_wdata / l_wdata  in  XLEN  store data, byte i = bits [8i+7:8i]
- c_rsp_valid / l_rsp_valid  out  1  one-cycle completion pulse, no backpressure
- rsp_rdata  out  XLEN  load result, valid with either rsp_valid, else 0
- rsp_err  out  1  error flag, valid with either rsp_valid, else 0
- mem_en  out  1  byte access strobe
- mem_we  out  1  byte write
- mem_addr  out  ADDR_W  byte address
- mem_wdata  out  8  write byte
- mem_rdata  in  8  read byte, valid the cycle after a read strobe

## Operation
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE: x_req_ready = x_req_valid && x granted; at most one ready high. On accept, capture we, size, addr, wdata and set byte count N (B/BU=1, H/HU=2, W=4), then go to ISSUE.
- Arbitration happens in IDLE only. If both are valid, grant the port not granted last. The last-grant register resets to L, so C wins the first tie.
- Error at accept: addr[XLEN-1:ADDR_W] nonzero, load funct3 in {011,110,111}, or store funct3 not in {000,001,010}. The block makes no memory access, stays in IDLE, and pulses rsp next cycle with err=1, rdata=0.
- ISSUE: byte i (0..N-1) per cycle: mem_en=1, mem_we=we, mem_addr=addr[ADDR_W-1:0]+i modulo 2^ADDR_W (wraps at the top of memory), mem_wdata=wdata[8i+7:8i].
  - Store: after byte N-1, go to IDLE.
  - Load: after byte N-1, go to DRAIN.
- Load capture: mem_rdata sampled the cycle after each strobe into byte lane i. DRAIN captures the last byte, then goes to IDLE.
- Extension: B/H take bit 8N-1 as sign; BU/HU zero-fill; W has no extension.
- Misaligned addresses are legal. There are no alignment restrictions.
- Response: registered; rsp_valid of the granted port high for exactly one cycle, coincident with return to IDLE.
- Request fields need only be stable in the accept cycle.

## Timing
- Reset values: all outputs 0. FSM = IDLE, byte count 0, last-grant = L, capture registers 0. x_req_ready is 0 during reset and 1 (if valid and granted) from the first cycle after reset deasserts.
- Accept at cycle T. Bytes issued T+1..T+N.
  - Store rsp at T+N+1.
  - Load rsp at T+N+2.
  - Error rsp at T+1.
- Ready is high again in the rsp cycle, so a back-to-back accept is legal there. Store SW throughput: 1 per 5 cycles.
- Reset during ISSUE/DRAIN: next cycle IDLE, mem_en=0, transaction dropped, no rsp generated, partial stores left in memory.
- Both valid in rsp cycle: the port opposite the just-completed one wins.

## Structure
- Package dmem_pkg: funct3 size enum (SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU), FSM state enum, function size→byte count, function size legality (load/store).
- Sub-module rr_arb2: 2-request round-robin with last-grant register, enable input (update only on accept).
- Top holds FSM, byte counter, capture/assembly registers, extension, rsp pulse.

## Test plan
- C LW addr 0x10, memory bytes 0x10..0x13 = 11 22 33 44, accept at T: mem_addr 0x10..0x13 at T+1..T+4, c_rsp_valid at T+6, rsp_rdata=0x44332211.
- L SH addr 0xFFFF (ADDR_W=16) wdata 0x0000BEEF: writes EF@0xFFFF, BE@0x0000. Then C LH 0xFFFF → 0xFFFFBEEF; C LHU 0xFFFF → 0x0000BEEF.
- Both valid continuously from reset, all LB requests: grants C, L, C, L in order; each rsp goes to the correct port only.
- C LW addr 0x00010000 or size 011: no mem_en, c_rsp_valid at T+1 with rsp_err=1, rdata 0. L SB size 100 produces the same error response.
- rst_n low at T+2 of a SW: mem_en 0 from T+3, no rsp. Bytes 0..1 written, bytes 2..3 unchanged. Next C request accepted immediately after reset.

Source files
------------

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and helpers for the data memory access controller
package dmem_pkg;

  localparam int DMEM_XLEN   = 32;
  localparam int DMEM_ADDR_W = 16;

  typedef enum logic [2:0] {
    SZ_B  = 3'b000,
    SZ_H  = 3'b001,
    SZ_W  = 3'b010,
    SZ_BU = 3'b100,
    SZ_HU = 3'b101
  } size_e;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_e;

  // Number of byte beats a funct3 size needs; illegal codes never reach the sequencer.
  function automatic logic [2:0] size_bytes(input logic [2:0] size);
    case (size)
      SZ_H, SZ_HU: size_bytes = 3'd2;
      SZ_W:        size_bytes = 3'd4;
      default:     size_bytes = 3'd1;
    endcase
  endfunction

  // Stores only know the signed encodings; loads also take the unsigned ones.
  function automatic logic size_legal(input logic [2:0] size, input logic we);
    if (we) size_legal = size inside {SZ_B, SZ_H, SZ_W};
    else    size_legal = size inside {SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU};
  endfunction

  // Sign- or zero-extend an assembled little-endian load word.
  function automatic logic [DMEM_XLEN-1:0] load_extend(input logic [2:0] size,
                                                       input logic [DMEM_XLEN-1:0] word);
    case (size)
      SZ_B:    load_extend = {{(DMEM_XLEN-8){word[7]}}, word[7:0]};
      SZ_H:    load_extend = {{(DMEM_XLEN-16){word[15]}}, word[15:0]};
      SZ_BU:   load_extend = {{(DMEM_XLEN-8){1'b0}}, word[7:0]};
      SZ_HU:   load_extend = {{(DMEM_XLEN-16){1'b0}}, word[15:0]};
      default: load_extend = word;
    endcase
  endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// rtl/dmem_access_ctrl_if.sv - requester ports, shared response and byte memory bus
interface dmem_access_ctrl_if
  import dmem_pkg::*;
#(
  parameter int XLEN   = DMEM_XLEN,
  parameter int ADDR_W = DMEM_ADDR_W
);

  logic              c_req_valid, l_req_valid;
  logic              c_req_ready, l_req_ready;
  logic              c_we, l_we;
  logic [2:0]        c_size, l_size;
  logic [XLEN-1:0]   c_addr, l_addr;
  logic [XLEN-1:0]   c_wdata, l_wdata;
  logic              c_rsp_valid, l_rsp_valid;
  logic [XLEN-1:0]   rsp_rdata;
  logic              rsp_err;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;

  modport slave (
    input  c_req_valid, l_req_valid, c_we, l_we, c_size, l_size,
    input  c_addr, l_addr, c_wdata, l_wdata, mem_rdata,
    output c_req_ready, l_req_ready, c_rsp_valid, l_rsp_valid,
    output rsp_rdata, rsp_err, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output c_req_valid, l_req_valid, c_we, l_we, c_size, l_size,
    output c_addr, l_addr, c_wdata, l_wdata, mem_rdata,
    input  c_req_ready, l_req_ready, c_rsp_valid, l_rsp_valid,
    input  rsp_rdata, rsp_err, mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter, last grant updated only on accept
module rr_arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic req_c,
  input  logic req_l,
  input  logic en,
  output logic gnt_c,
  output logic gnt_l
);

  logic last_c_q;

  // On a tie the port that did not win last time gets the grant
  always_comb begin
    gnt_c = req_c && (!req_l || !last_c_q);
    gnt_l = req_l && (!req_c || last_c_q);
  end

  // Remember the winner; reset favours C by pretending L won last
  always_ff @(posedge clk) begin
    if (!rst_n)  last_c_q <= 1'b0;
    else if (en) last_c_q <= gnt_c;
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// rtl/dmem_access_ctrl.sv - arbitrated byte-serial load/store sequencer for the data memory
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter int XLEN   = DMEM_XLEN,
  parameter int ADDR_W = DMEM_ADDR_W
) (
  input logic               clk,
  input logic               rst_n,
  dmem_access_ctrl_if.slave bus
);

  state_e            state_q, state_d;
  logic              grant_c, grant_l, c_ready, l_ready, accept, acc_err, last_byte;
  logic              sel_we;
  logic [2:0]        sel_size;
  logic [XLEN-1:0]   sel_addr, sel_wdata;
  logic              we_q, owner_c_q;
  logic [2:0]        size_q, n_q;
  logic [1:0]        idx_q, cap_lane, fin_lane;
  logic [ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]   wdata_q, data_q, load_word, rdata_q;
  logic              c_rsp_q, l_rsp_q, err_q;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req_c (bus.c_req_valid),
    .req_l (bus.l_req_valid),
    .en    (accept),
    .gnt_c (grant_c),
    .gnt_l (grant_l)
  );

  // Ready only in IDLE out of reset; mux the granted request and screen it for errors
  always_comb begin
    c_ready   = rst_n && (state_q == IDLE) && grant_c;
    l_ready   = rst_n && (state_q == IDLE) && grant_l;
    accept    = c_ready || l_ready;
    sel_we    = grant_c ? bus.c_we    : bus.l_we;
    sel_size  = grant_c ? bus.c_size  : bus.l_size;
    sel_addr  = grant_c ? bus.c_addr  : bus.l_addr;
    sel_wdata = grant_c ? bus.c_wdata : bus.l_wdata;
    acc_err   = (sel_addr[XLEN-1:ADDR_W] != '0) || !size_legal(sel_size, sel_we);
    last_byte = ({1'b0, idx_q} == (n_q - 3'd1));
    cap_lane  = idx_q - 2'd1;
    fin_lane  = n_q[1:0] - 2'd1;
  end

  assign bus.c_req_ready = c_ready;
  assign bus.l_req_ready = l_ready;

  // Next state and byte-port strobes; addresses wrap naturally at ADDR_W bits
  always_comb begin
    state_d       = state_q;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    case (state_q)
      IDLE: if (accept && !acc_err) state_d = ISSUE;
      ISSUE: begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = we_q;
        bus.mem_addr  = addr_q + ADDR_W'(idx_q);
        bus.mem_wdata = wdata_q[8*idx_q +: 8];
        if (last_byte) state_d = we_q ? IDLE : DRAIN;
      end
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Final load word: earlier lanes from the capture register, last lane straight from memory
  always_comb begin
    load_word = data_q;
    load_word[8*fin_lane +: 8] = bus.mem_rdata;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Capture the accepted request, step the byte index and collect returning load bytes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_q      <= 1'b0;
      owner_c_q <= 1'b0;
      size_q    <= '0;
      n_q       <= '0;
      idx_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      data_q    <= '0;
    end else begin
      case (state_q)
        IDLE: if (accept && !acc_err) begin
          we_q      <= sel_we;
          owner_c_q <= grant_c;
          size_q    <= sel_size;
          n_q       <= size_bytes(sel_size);
          idx_q     <= '0;
          addr_q    <= sel_addr[ADDR_W-1:0];
          wdata_q   <= sel_wdata;
          data_q    <= '0;
        end
        ISSUE: begin
          idx_q <= idx_q + 2'd1;
          if (idx_q != 2'd0) data_q[8*cap_lane +: 8] <= bus.mem_rdata;
        end
        default: ;
      endcase
    end
  end

  // One-cycle completion pulse to the owning port; data and error are zero otherwise
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      c_rsp_q <= 1'b0;
      l_rsp_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      c_rsp_q <= 1'b0;
      l_rsp_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      case (state_q)
        IDLE: if (accept && acc_err) begin
          c_rsp_q <= grant_c;
          l_rsp_q <= grant_l;
          err_q   <= 1'b1;
        end
        ISSUE: if (last_byte && we_q) begin
          c_rsp_q <= owner_c_q;
          l_rsp_q <= !owner_c_q;
        end
        DRAIN: begin
          c_rsp_q <= owner_c_q;
          l_rsp_q <= !owner_c_q;
          rdata_q <= load_extend(size_q, load_word);
        end
        default: ;
      endcase
    end
  end

  assign bus.c_rsp_valid = c_rsp_q;
  assign bus.l_rsp_valid = l_rsp_q;
  assign bus.rsp_err     = err_q;
  assign bus.rsp_rdata   = rdata_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb/tb_dmem_access_ctrl.sv - directed self-checking bench for dmem_access_ctrl
module tb_dmem_access_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  dmem_access_ctrl_if bus ();

  dmem_access_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [7:0] mem [0:65535];
  logic [7:0] rd_q = 8'h00;

  // Byte memory model: one-cycle read latency
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else            rd_q <= mem[bus.mem_addr];
    end
  end

  assign bus.mem_rdata = rd_q;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.c_req_valid = 1'b0; bus.l_req_valid = 1'b0;
    bus.c_we = 1'b0;        bus.l_we = 1'b0;
    bus.c_size = 3'b000;    bus.l_size = 3'b000;
    bus.c_addr = '0;        bus.l_addr = '0;
    bus.c_wdata = '0;       bus.l_wdata = '0;
  endtask

  task automatic issue(input logic port_l, input logic we, input logic [2:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata, output int waited);
    @(posedge clk); #1;
    if (port_l) begin
      bus.l_req_valid = 1'b1; bus.l_we = we; bus.l_size = size; bus.l_addr = addr; bus.l_wdata = wdata;
    end else begin
      bus.c_req_valid = 1'b1; bus.c_we = we; bus.c_size = size; bus.c_addr = addr; bus.c_wdata = wdata;
    end
    waited = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (port_l ? bus.l_req_ready : bus.c_req_ready) begin
        waited = i;
        break;
      end
    end
    @(posedge clk); #1;
    bus.c_req_valid = 1'b0; bus.l_req_valid = 1'b0;
    bus.c_addr = 32'hFFFF_FFFF; bus.l_addr = 32'hFFFF_FFFF;
    bus.c_wdata = 32'h5A5A_5A5A; bus.l_wdata = 32'h5A5A_5A5A;
    bus.c_size = 3'b111; bus.l_size = 3'b111;
    check_eq("accept_seen", 32'(waited >= 0), 32'd1);
  endtask

  task automatic txn(input string tag, input logic port_l, input logic we, input logic [2:0] size,
                     input logic [31:0] addr, input logic [31:0] wdata, input int exp_lat,
                     input logic [31:0] exp_rdata, input logic exp_err, input int exp_en,
                     input logic [15:0] exp_first, input logic [15:0] exp_last);
    int          waited, lat, en_cnt;
    logic        c_hit, l_hit, err;
    logic [31:0] rdata;
    logic [15:0] first_a, last_a;
    issue(port_l, we, size, addr, wdata, waited);
    lat = -1; en_cnt = 0; c_hit = 0; l_hit = 0; err = 0; rdata = '0; first_a = '0; last_a = '0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.mem_en) begin
        if (en_cnt == 0) first_a = bus.mem_addr;
        last_a = bus.mem_addr;
        en_cnt++;
      end
      if (bus.c_rsp_valid || bus.l_rsp_valid) begin
        lat = k; c_hit = bus.c_rsp_valid; l_hit = bus.l_rsp_valid;
        rdata = bus.rsp_rdata; err = bus.rsp_err;
        break;
      end
    end
    check_eq({tag, "_wait"}, waited, 0);
    check_eq({tag, "_lat"}, lat, exp_lat);
    check_eq({tag, "_port"}, {30'd0, c_hit, l_hit}, port_l ? 32'd1 : 32'd2);
    check_eq({tag, "_rdata"}, rdata, exp_rdata);
    check_eq({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
    check_eq({tag, "_bytes"}, en_cnt, exp_en);
    if (exp_en > 0) begin
      check_eq({tag, "_first_addr"}, {16'd0, first_a}, {16'd0, exp_first});
      check_eq({tag, "_last_addr"}, {16'd0, last_a}, {16'd0, exp_last});
    end
  endtask

  initial begin
    int          w;
    int          n_grant, n_rsp, n_both;
    logic [4:0]  g_bits;
    logic [3:0]  r_bits;

    idle_inputs();
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0010] = 8'h11; mem[16'h0011] = 8'h22; mem[16'h0012] = 8'h33; mem[16'h0013] = 8'h44;
    mem[16'h0020] = 8'h80; mem[16'h0021] = 8'h7F;

    // Reset: a pending C request must not be readied
    bus.c_req_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_c_ready", {31'd0, bus.c_req_ready}, 32'd0);
    check_eq("rst_mem_en", {31'd0, bus.mem_en}, 32'd0);
    check_eq("rst_rsp", {30'd0, bus.c_rsp_valid, bus.l_rsp_valid}, 32'd0);
    check_eq("rst_rdata", bus.rsp_rdata, 32'd0);
    check_eq("rst_err", {31'd0, bus.rsp_err}, 32'd0);
    @(posedge clk); #1;
    bus.c_req_valid = 1'b0;
    rst_n = 1'b1;

    txn("lw",       1'b0, 1'b0, 3'b010, 32'h10,   32'h0,        6, 32'h44332211, 1'b0, 4, 16'h0010, 16'h0013);
    txn("sh_wrap",  1'b1, 1'b1, 3'b001, 32'hFFFF, 32'h0000BEEF, 3, 32'h0,        1'b0, 2, 16'hFFFF, 16'h0000);
    check_eq("sh_mem_ffff", {24'd0, mem[16'hFFFF]}, 32'hEF);
    check_eq("sh_mem_0000", {24'd0, mem[16'h0000]}, 32'hBE);
    txn("lh_wrap",  1'b0, 1'b0, 3'b001, 32'hFFFF, 32'h0,        4, 32'hFFFFBEEF, 1'b0, 2, 16'hFFFF, 16'h0000);
    txn("lhu_wrap", 1'b0, 1'b0, 3'b101, 32'hFFFF, 32'h0,        4, 32'h0000BEEF, 1'b0, 2, 16'hFFFF, 16'h0000);
    txn("lb_neg",   1'b0, 1'b0, 3'b000, 32'h20,   32'h0,        3, 32'hFFFFFF80, 1'b0, 1, 16'h0020, 16'h0020);
    txn("lbu_l",    1'b1, 1'b0, 3'b100, 32'h20,   32'h0,        3, 32'h00000080, 1'b0, 1, 16'h0020, 16'h0020);
    txn("lh_mis",   1'b0, 1'b0, 3'b001, 32'h21,   32'h0,        4, 32'h0000007F, 1'b0, 2, 16'h0021, 16'h0022);
    txn("err_addr", 1'b0, 1'b0, 3'b010, 32'h00010000, 32'h0,    1, 32'h0,        1'b1, 0, 16'h0, 16'h0);
    txn("err_f3",   1'b0, 1'b0, 3'b011, 32'h10,   32'h0,        1, 32'h0,        1'b1, 0, 16'h0, 16'h0);
    txn("err_sb4",  1'b1, 1'b1, 3'b100, 32'h10,   32'h0,        1, 32'h0,        1'b1, 0, 16'h0, 16'h0);
    check_eq("err_no_write", {24'd0, mem[16'h0010]}, 32'h11);
    txn("sw",       1'b0, 1'b1, 3'b010, 32'h40,   32'hA1B2C3D4, 5, 32'h0,        1'b0, 4, 16'h0040, 16'h0043);
    check_eq("sw_mem", {mem[16'h0043], mem[16'h0042], mem[16'h0041], mem[16'h0040]}, 32'hA1B2C3D4);
    txn("lw_back",  1'b1, 1'b0, 3'b010, 32'h40,   32'h0,        6, 32'hA1B2C3D4, 1'b0, 4, 16'h0040, 16'h0043);

    // Reset in the second issue cycle of a store: two bytes land, no response
    issue(1'b0, 1'b1, 3'b010, 32'h50, 32'h04030201, w);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_mid_mem_en", {31'd0, bus.mem_en}, 32'd0);
    check_eq("rst_mid_rsp", {30'd0, bus.c_rsp_valid, bus.l_rsp_valid}, 32'd0);
    check_eq("rst_mid_mem", {mem[16'h0053], mem[16'h0052], mem[16'h0051], mem[16'h0050]}, 32'h00000201);
    txn("lw_after_rst", 1'b0, 1'b0, 3'b010, 32'h50, 32'h0,    6, 32'h00000201, 1'b0, 4, 16'h0050, 16'h0053);

    // Both ports request LB continuously from reset: C, L, C, L...
    @(posedge clk); #1;
    rst_n = 1'b0;
    bus.c_req_valid = 1'b1; bus.c_we = 1'b0; bus.c_size = 3'b000; bus.c_addr = 32'h10;
    bus.l_req_valid = 1'b1; bus.l_we = 1'b0; bus.l_size = 3'b000; bus.l_addr = 32'h13;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    n_grant = 0; n_rsp = 0; n_both = 0; g_bits = '0; r_bits = '0;
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      if (bus.c_req_ready && bus.l_req_ready) n_both++;
      if (bus.c_req_ready) begin g_bits = {g_bits[3:0], 1'b0}; n_grant++; end
      if (bus.l_req_ready) begin
        g_bits = {g_bits[3:0], 1'b1}; n_grant++;
        check_eq("rr_l_grant_in_c_rsp", {31'd0, bus.c_rsp_valid}, 32'd1);
      end
      if (bus.c_rsp_valid) begin
        r_bits = {r_bits[2:0], 1'b0}; n_rsp++;
        check_eq("rr_c_rdata", bus.rsp_rdata, 32'h00000011);
      end
      if (bus.l_rsp_valid) begin
        r_bits = {r_bits[2:0], 1'b1}; n_rsp++;
        check_eq("rr_l_rdata", bus.rsp_rdata, 32'h00000044);
      end
    end
    @(posedge clk); #1;
    idle_inputs();
    check_eq("rr_both_ready", n_both, 0);
    check_eq("rr_grant_cnt", n_grant, 5);
    check_eq("rr_grant_order", {27'd0, g_bits}, 32'b01010);
    check_eq("rr_rsp_cnt", n_rsp, 4);
    check_eq("rr_rsp_order", {28'd0, r_bits}, 32'b0101);
    repeat (6) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
